// File: rtl/comparator_pkg.sv
//==============================================================================
// Module      : comparator_pkg
// Description : Shared state encoding and slice width for the comparator sequencer.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package comparator_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CMP  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam int SLICE_W = 2;

endpackage : comparator_pkg

`default_nettype wire

// File: rtl/comparator_2b2b_struc.sv
//==============================================================================
// Module      : comparator_2b2b_struc
// Description : Structural 2-bit magnitude comparator, AB vs CD (A, C are MSBs).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module comparator_2b2b_struc (
    input  logic A,
    input  logic B,
    input  logic C,
    input  logic D,
    output logic F1,
    output logic F2,
    output logic F3
);

    logic w_eq_hi;
    logic w_eq_lo;

    assign w_eq_hi = A ~^ C;
    assign w_eq_lo = B ~^ D;

    // The MSB pair decides unless it ties; only then does the LSB pair matter.
    assign F1 = (A & ~C) | (w_eq_hi & B & ~D);
    assign F2 = w_eq_hi & w_eq_lo;
    assign F3 = (~A & C) | (w_eq_hi & ~B & D);

endmodule : comparator_2b2b_struc

`default_nettype wire

// File: rtl/comparator_seq_ctrl.sv
//==============================================================================
// Module      : comparator_seq_ctrl
// Description : MSB-first sequential magnitude compare using one shared 2-bit
//               comparator, with early exit and a start/done handshake.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module comparator_seq_ctrl
    import comparator_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 start,
    input  logic [WIDTH-1:0]                     a,
    input  logic [WIDTH-1:0]                     b,
    output logic                                 busy,
    output logic                                 done,
    output logic                                 gt,
    output logic                                 eq,
    output logic                                 lt,
    output logic [$clog2(WIDTH/2)+1-1:0]         slices
);

    localparam int NSLICE = WIDTH / 2;
    localparam int SL_W   = $clog2(NSLICE) + 1;

    localparam logic [SL_W-1:0] c_last_cnt = SL_W'(NSLICE - 1);
    localparam logic [SL_W-1:0] c_nslice   = SL_W'(NSLICE);

    generate
        if ((WIDTH % 2) != 0 || WIDTH < 2) begin : g_bad_width
            $error("comparator_seq_ctrl: WIDTH must be even and >= 2");
        end
    endgenerate

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_sa;
    logic [WIDTH-1:0] r_sb;
    logic [SL_W-1:0]  r_cnt;
    logic             r_gt;
    logic             r_eq;
    logic             r_lt;
    logic [SL_W-1:0]  r_slices;

    logic w_f1;
    logic w_f2;
    logic w_f3;

    comparator_2b2b_struc u_cmp (
        .A  (r_sa[WIDTH-1]),
        .B  (r_sa[WIDTH-2]),
        .C  (r_sb[WIDTH-1]),
        .D  (r_sb[WIDTH-2]),
        .F1 (w_f1),
        .F2 (w_f2),
        .F3 (w_f3)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_sa     <= '0;
            r_sb     <= '0;
            r_cnt    <= '0;
            r_gt     <= 1'b0;
            r_eq     <= 1'b0;
            r_lt     <= 1'b0;
            r_slices <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_sa     <= a;
                        r_sb     <= b;
                        r_cnt    <= '0;
                        r_gt     <= 1'b0;
                        r_eq     <= 1'b0;
                        r_lt     <= 1'b0;
                        r_slices <= '0;
                        r_state  <= ST_CMP;
                    end
                end
                ST_CMP: begin
                    // F2 is implied when neither F1 nor F3 fires.
                    if (w_f1 || w_f3) begin
                        r_gt     <= w_f1;
                        r_lt     <= w_f3;
                        r_eq     <= 1'b0;
                        r_slices <= r_cnt + 1'b1;
                        r_state  <= ST_DONE;
                    end else if (r_cnt == c_last_cnt) begin
                        r_gt     <= 1'b0;
                        r_lt     <= 1'b0;
                        r_eq     <= 1'b1;
                        r_slices <= c_nslice;
                        r_state  <= ST_DONE;
                    end else begin
                        r_sa  <= r_sa << SLICE_W;
                        r_sb  <= r_sb << SLICE_W;
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    logic w_unused_f2;
    assign w_unused_f2 = w_f2;

    assign busy   = (r_state == ST_CMP);
    assign done   = (r_state == ST_DONE);
    assign gt     = r_gt;
    assign eq     = r_eq;
    assign lt     = r_lt;
    assign slices = r_slices;

endmodule : comparator_seq_ctrl

`default_nettype wire

// File: tb/tb_comparator_seq_ctrl.sv
//==============================================================================
// Module      : tb_comparator_seq_ctrl
// Description : Directed self-checking bench for comparator_seq_ctrl (WIDTH=8).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_comparator_seq_ctrl;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       busy;
    logic       done;
    logic       gt;
    logic       eq;
    logic       lt;
    logic [2:0] slices;

    int checks = 0;
    int errors = 0;

    comparator_seq_ctrl #(.WIDTH(8)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .gt     (gt),
        .eq     (eq),
        .lt     (lt),
        .slices (slices)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issues a one-cycle start and waits (bounded) for done.
    task automatic do_cmp(input logic [7:0] ia, input logic [7:0] ib,
                          output int lat, output int bcy);
        a = ia;
        b = ib;
        start = 1'b1;
        tick();
        start = 1'b0;
        lat = 0;
        bcy = 0;
        while (!done && lat < 20) begin
            if (busy) bcy++;
            tick();
            lat++;
        end
    endtask

    task automatic chk_res(input string tag, input logic egt, input logic eeq,
                           input logic elt, input logic [2:0] esl);
        chk({tag, ".gt"}, {31'd0, gt}, {31'd0, egt});
        chk({tag, ".eq"}, {31'd0, eq}, {31'd0, eeq});
        chk({tag, ".lt"}, {31'd0, lt}, {31'd0, elt});
        chk({tag, ".slices"}, {29'd0, slices}, {29'd0, esl});
    endtask

    initial begin
        int lat;
        int bcy;

        rst_n = 1'b0;
        start = 1'b0;
        a = 8'h00;
        b = 8'h00;
        tick();
        tick();
        chk("rst.busy", {31'd0, busy}, 32'd0);
        chk("rst.done", {31'd0, done}, 32'd0);
        chk_res("rst", 1'b0, 1'b0, 1'b0, 3'd0);
        rst_n = 1'b1;
        tick();

        // B4 vs 74: MSB slice 10 > 01
        a = 8'hB4;
        b = 8'h74;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("t1.busy", {31'd0, busy}, 32'd1);
        chk_res("t1.clr", 1'b0, 1'b0, 1'b0, 3'd0);
        tick();
        chk("t1.done", {31'd0, done}, 32'd1);
        chk("t1.busy_off", {31'd0, busy}, 32'd0);
        chk_res("t1", 1'b1, 1'b0, 1'b0, 3'd1);
        tick();
        chk("t1.done_pulse", {31'd0, done}, 32'd0);
        chk_res("t1.hold", 1'b1, 1'b0, 1'b0, 3'd1);

        // Equal operands run all four slices
        do_cmp(8'h5A, 8'h5A, lat, bcy);
        chk("t2.latency", lat, 32'd4);
        chk("t2.busy_cycles", bcy, 32'd4);
        chk_res("t2", 1'b0, 1'b1, 1'b0, 3'd4);
        tick();
        chk("t2.done_pulse", {31'd0, done}, 32'd0);

        // Decided at last slice: 10 < 11
        do_cmp(8'h12, 8'h13, lat, bcy);
        chk("t3.latency", lat, 32'd4);
        chk_res("t3", 1'b0, 1'b0, 1'b1, 3'd4);
        tick();

        // Last-slice greater: FF vs FE
        do_cmp(8'hFF, 8'hFE, lat, bcy);
        chk("t3b.latency", lat, 32'd4);
        chk_res("t3b", 1'b1, 1'b0, 1'b0, 3'd4);
        tick();

        // Start and operand changes during CMP are ignored
        a = 8'h40;
        b = 8'h00;
        start = 1'b1;
        tick();
        a = 8'h00;
        b = 8'hFF;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("t4.done", {31'd0, done}, 32'd1);
        chk_res("t4", 1'b1, 1'b0, 1'b0, 3'd1);
        tick();
        chk("t4.idle_done", {31'd0, done}, 32'd0);
        chk("t4.idle_busy", {31'd0, busy}, 32'd0);
        tick();
        chk("t4.no_redo", {31'd0, done}, 32'd0);
        chk_res("t4.hold", 1'b1, 1'b0, 1'b0, 3'd1);

        // Async reset mid-compare
        a = 8'h5A;
        b = 8'h5A;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5.busy", {31'd0, busy}, 32'd0);
        chk("t5.done", {31'd0, done}, 32'd0);
        chk_res("t5", 1'b0, 1'b0, 1'b0, 3'd0);
        tick();
        tick();
        chk("t5.no_done", {31'd0, done}, 32'd0);
        rst_n = 1'b1;
        tick();
        chk("t5.idle", {31'd0, busy}, 32'd0);
        do_cmp(8'h01, 8'h02, lat, bcy);
        chk("t5b.latency", lat, 32'd4);
        chk_res("t5b", 1'b0, 1'b0, 1'b1, 3'd4);
        tick();

        // Start held high: IDLE -> CMP -> DONE repeats every 3 cycles
        a = 8'hC0;
        b = 8'h80;
        start = 1'b1;
        for (int r = 0; r < 3; r++) begin
            tick();
            chk("t6.busy", {31'd0, busy}, 32'd1);
            chk_res("t6.clr", 1'b0, 1'b0, 1'b0, 3'd0);
            tick();
            chk("t6.done", {31'd0, done}, 32'd1);
            chk_res("t6", 1'b1, 1'b0, 1'b0, 3'd1);
            tick();
            chk("t6.idle", {31'd0, done | busy}, 32'd0);
        end
        start = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_comparator_seq_ctrl

`default_nettype wire

// File: doc/comparator_seq_ctrl.md
Name: comparator_seq_ctrl

Overview:
- Sequencer that compares two WIDTH-bit unsigned words using one shared 2-bit/2-bit magnitude comparator (comparator_2b2b_struc).
- Feeds the comparator one 2-bit slice per clock, MSB slice first.
- Terminates early on the first unequal slice; otherwise finishes after WIDTH/2 slices.
- Sits between a requesting datapath and the comparator; start/done handshake; registered results.

Parameters:
- WIDTH, 8, operand width in bits; must be even and >= 2 (elaboration error otherwise).
- NSLICE, WIDTH/2, number of 2-bit slices (derived localparam, not overridable).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request pulse; sampled only in IDLE.
- a  input  WIDTH  operand A, captured on the accepted start edge.
- b  input  WIDTH  operand B, captured on the accepted start edge.
- busy  output  1  high while in CMP.
- done  output  1  one-cycle pulse when the result is valid.
- gt  output  1  a > b (registered, held until next accepted start).
- eq  output  1  a == b (registered, held).
- lt  output  1  a < b (registered, held).
- slices  output  $clog2(NSLICE)+1  number of slices evaluated for the last result (1..NSLICE).

Behaviour:
- Reset (async assert, sync release): state=IDLE; busy=0, done=0, gt=0, eq=0, lt=0, slices=0; shift registers and slice counter = 0.
- States: IDLE, CMP, DONE.
- IDLE -> CMP on start=1:
  - load sa<=a, sb<=b; cnt<=0.
  - clear gt/eq/lt/slices on the same edge.
- CMP: busy=1. Comparator inputs are {A,B}=sa[WIDTH-1:WIDTH-2], {C,D}=sb[WIDTH-1:WIDTH-2].
- Comparator contract: F1 = AB>CD, F2 = AB==CD, F3 = AB<CD; exactly one output is high.
- On each CMP edge:
  - if F1 or F3: gt<=F1, lt<=F3, eq<=0, slices<=cnt+1, go DONE.
  - else if cnt==NSLICE-1: eq<=1, gt<=0, lt<=0, slices<=NSLICE, go DONE.
  - else: sa<=sa<<2, sb<<=sb<<2, cnt<=cnt+1, stay in CMP.
- DONE: done=1 for exactly one cycle; busy=0; unconditionally -> IDLE.
- Latency: start edge to done-high = k+1 cycles, where k is the 0-based index of the deciding slice (MSB slice = 0). Max NSLICE cycles.
- start while in CMP or DONE is ignored; no queuing.
- Back-to-back: earliest re-accept is the edge after DONE, i.e. a start held high through DONE is taken in IDLE.
- a and b may change freely after the accepting edge without effect.
- Results stay stable from the DONE cycle until the next accepted start.
- Reset mid-operation aborts immediately to reset values; no done pulse.
- Exactly one of gt/eq/lt is high after any completed compare; all three are 0 only after reset or while a compare is in flight.

Decomposition:
- Shared package comparator_pkg:
  - state encoding localparams: ST_IDLE=2'd0, ST_CMP=2'd1, ST_DONE=2'd2.
  - slice width constant SLICE_W=2.
- Single sub-module instance: comparator_2b2b_struc (existing structural comparator, unchanged). No other sub-modules; FSM, shifters and counter are inline.

Test Plan (WIDTH=8):
- a=8'hB4, b=8'h74, start 1 cycle -> slice0 10>01; done 1 cycle after start edge; gt=1, eq=0, lt=0, slices=1.
- a=8'h5A, b=8'h5A -> done 4 cycles after start; eq=1, gt=0, lt=0, slices=4; busy high exactly 4 cycles.
- a=8'h12, b=8'h13 -> decided at slice3 (10<11); done after 4 cycles; lt=1, slices=4.
- a=8'h40, b=8'h00; pulse start again plus change a/b to 8'h00/8'hFF during CMP -> second start ignored; result gt=1, slices=1; exactly one done pulse.
- Start a=8'h5A, b=8'h5A; assert rst_n=0 at cycle 2 -> outputs immediately 0, state IDLE, no done. After release, a=8'h01, b=8'h02 -> lt=1, slices=4.
- Hold start=1 continuously with a=8'hC0, b=8'h80 -> done pulses every 3 cycles (IDLE, CMP, DONE); gt=1, slices=1 each time.
